// File: rtl/mips150_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips150_pkg
// Description : Shared types and constants for the MIPS150 fetch stage.
//               Provides the fetch FSM state encoding, the default reset PC,
//               the instruction buffer depth and a word-alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package mips150_pkg;

    // Fetch FSM states: IDLE issues nothing, RUN fetches continuously
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // First fetch address after reset unless overridden
    localparam logic [31:0] c_reset_pc  = 32'h0000_0000;

    // Instruction buffer entry count (the buffer is built for exactly two)
    localparam int          c_buf_depth = 2;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips150_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : mips150_fetch_buf
// Description : Two-entry instruction/PC FIFO between instruction memory and
//               the decoder. Supports simultaneous push and pop, and a flush
//               that empties it at the clock edge. The head outputs read as
//               zero whenever the buffer is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module mips150_fetch_buf
    import mips150_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        push,
    input  logic [31:0] push_instr,
    input  logic [31:0] push_pc,
    input  logic        pop,
    output logic [31:0] head_instr,
    output logic [31:0] head_pc,
    output logic        full,
    output logic        empty
);

    logic [31:0] r_instr [0:1];
    logic [31:0] r_pc    [0:1];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic        w_do_push;
    logic        w_do_pop;

    assign full  = (r_count == 2'd2);
    assign empty = (r_count == 2'd0);

    // A pop frees a slot in the same cycle, so push into a full buffer is
    // legal only alongside a pop; popping an empty buffer is ignored.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign head_instr = empty ? 32'h0 : r_instr[r_rd_ptr];
    assign head_pc    = empty ? 32'h0 : r_pc[r_rd_ptr];

    // Storage, pointers and occupancy; flush discards all held entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_instr[i] <= 32'h0;
                r_pc[i]    <= 32'h0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_instr[r_wr_ptr] <= push_instr;
                r_pc[r_wr_ptr]    <= push_pc;
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips150_fetch.sv
`default_nettype none
// ============================================================================
// Module      : mips150_fetch
// Description : MIPS150 instruction fetch stage. Issues word reads to a
//               synchronous (one-cycle latency) instruction memory, captures
//               responses in a two-entry buffer and presents them to the
//               decoder with a valid/ready handshake. A redirect pulse flushes
//               the buffer, drops the in-flight response and restarts fetch
//               at the new target.
//               Optional feature: define MIPS150_FETCH_PERF_EN to add the
//               fetch_count transfer counter output.
// Revision    : 1.0 - initial release
// ============================================================================
module mips150_fetch
    import mips150_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_reset_pc,
    parameter int          BUF_DEPTH = c_buf_depth
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
`ifdef MIPS150_FETCH_PERF_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam logic [2:0] c_depth_w = 3'(BUF_DEPTH);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_pend;
    logic [31:0]  r_pend_pc;

    logic         w_running;
    logic         w_redirect;
    logic         w_pop;
    logic         w_push;
    logic         w_req;
    logic         w_buf_full;
    logic         w_buf_empty;
    logic [2:0]   w_held;
    logic [2:0]   w_occ;

    assign w_running  = (r_state == ST_RUN);
    // Redirects only matter once fetching has started
    assign w_redirect = redirect & w_running;
    assign w_pop      = instr_valid & instr_ready;
    // A response belongs in the buffer unless a redirect makes it stale
    assign w_push     = r_pend & ~w_redirect;

    assign w_held = w_buf_full ? 3'd2 : (w_buf_empty ? 3'd0 : 3'd1);
    // Slots that will be claimed after this cycle's handshake
    assign w_occ  = w_held + {2'b00, r_pend} - {2'b00, w_pop};

    assign w_req     = w_running & ~w_redirect & (w_occ < c_depth_w);
    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    assign instr_valid = ~w_buf_empty;

    mips150_fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (w_redirect),
        .push       (w_push),
        .push_instr (imem_rdata),
        .push_pc    (r_pend_pc),
        .pop        (w_pop),
        .head_instr (instr),
        .head_pc    (instr_pc),
        .full       (w_buf_full),
        .empty      (w_buf_empty)
    );

    // Fetch FSM, PC sequencing and tracking of the single in-flight read
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= word_align(RESET_PC);
            r_pend    <= 1'b0;
            r_pend_pc <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_redirect) begin
                        r_pc <= word_align(redirect_pc);
                    end else if (w_req) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
            r_pend <= w_req;
            if (w_req) begin
                r_pend_pc <= r_pc;
            end
        end
    end

`ifdef MIPS150_FETCH_PERF_EN
    // Count every completed decoder handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_count <= 32'h0;
        end else if (w_pop) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mips150_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips150_fetch
// Description : Self-checking bench for mips150_fetch. Memory returns
//               word = address; a scoreboard tracks the next PC the decoder
//               must see, jumping on redirect and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips150_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
`ifdef MIPS150_FETCH_PERF_EN
    logic [31:0] fetch_count;
`endif

    int          compared   = 0;
    int          mismatched = 0;

    // Reference model state
    logic [31:0] exp_pc     = RESET_PC;
    logic        running    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc    = 32'h0;
    logic [31:0] prev_instr = 32'h0;
    int          xfers      = 0;
    int          starve     = 0;
    int          max_starve = 0;

    mips150_fetch #(
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
`ifdef MIPS150_FETCH_PERF_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous BRAM: word equals its address; garbage when not read
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr;
        else          imem_rdata <= $urandom;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Observe the current cycle (inputs already applied) and update the model
    task automatic sample();
        #1;
        if (prev_stall) begin
            chkb("hold_valid", instr_valid, 1'b1);
            chk("hold_pc", instr_pc, prev_pc);
            chk("hold_instr", instr, prev_instr);
        end
        if (imem_req === 1'b1)
            chk("addr_align", {30'b0, imem_addr[1:0]}, 32'h0);
        if (rst_n && instr_valid && instr_ready) begin
            chk("xfer_pc", instr_pc, exp_pc);
            chk("xfer_data", instr, exp_pc);
            exp_pc = exp_pc + 32'd4;
            xfers++;
        end
        prev_stall = rst_n && instr_valid && !instr_ready && !(redirect && running);
        prev_pc    = instr_pc;
        prev_instr = instr;
        if (!rst_n || (redirect && running) || !instr_ready || instr_valid)
            starve = 0;
        else
            starve++;
        if (starve > max_starve) max_starve = starve;
        if (!rst_n) begin
            exp_pc  = RESET_PC;
            running = 1'b0;
        end else begin
            if (redirect && running) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            running = 1'b1;
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        @(posedge clk); #1;
        repeat (3) step();

        // Reset state
        sample();
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        advance();

        // Reset release: IDLE for one cycle, then streaming from RESET_PC
        rst_n = 1'b1;
        sample(); chkb("idle_req", imem_req, 1'b0); advance();
        sample();
        chkb("first_req", imem_req, 1'b1);
        chk("first_addr", imem_addr, RESET_PC);
        chkb("first_valid", instr_valid, 1'b0);
        advance();
        sample();
        chkb("lat1_valid", instr_valid, 1'b0);
        chk("second_addr", imem_addr, RESET_PC + 32'd4);
        advance();
        for (int i = 0; i < 3; i++) begin
            sample();
            chkb("stream_valid", instr_valid, 1'b1);
            chk("stream_pc", instr_pc, RESET_PC + 32'(4 * i));
            advance();
        end

        // Decoder stall: two held or in flight means no further reads
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(); chkb("stall_req", imem_req, 1'b0); advance();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sample(); chkb("release_valid", instr_valid, 1'b1); advance();
        end

        // Redirect with a full buffer and a handshake in the same cycle
        instr_ready = 1'b0;
        repeat (2) step();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
        sample(); chkb("redir_req", imem_req, 1'b0); advance();
        redirect = 1'b0;
        sample();
        chkb("redir_tgt_req", imem_req, 1'b1);
        chk("redir_tgt_addr", imem_addr, 32'h0000_0100);
        chkb("redir_gap1", instr_valid, 1'b0);
        advance();
        sample(); chkb("redir_gap2", instr_valid, 1'b0); advance();
        sample();
        chkb("redir_valid", instr_valid, 1'b1);
        chk("redir_pc", instr_pc, 32'h0000_0100);
        advance();
        repeat (3) step();

        // Redirect to the top word: PC wraps to zero
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        sample(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); advance();
        sample(); chk("wrap_addr1", imem_addr, 32'h0000_0000); advance();
        sample();
        chkb("wrap_valid0", instr_valid, 1'b1);
        chk("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
        advance();
        sample();
        chkb("wrap_valid1", instr_valid, 1'b1);
        chk("wrap_pc1", instr_pc, 32'h0000_0000);
        advance();
        repeat (2) step();

        // One-cycle reset with a full buffer
        instr_ready = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; instr_ready = 1'b1;
        sample();
        chkb("mrst_valid", instr_valid, 1'b0);
        chkb("mrst_req", imem_req, 1'b0);
        chk("mrst_instr", instr, 32'h0);
        advance();
        sample();
        chkb("mrst_restart_req", imem_req, 1'b1);
        chk("mrst_restart_addr", imem_addr, RESET_PC);
        advance();
        step();
        sample();
        chkb("mrst_valid2", instr_valid, 1'b1);
        chk("mrst_pc", instr_pc, RESET_PC);
        advance();

        // Randomized traffic with redirects and occasional resets
        for (int i = 0; i < 400; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            rst_n       = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_n = 1'b1; redirect = 1'b0; instr_ready = 1'b1;
        repeat (4) step();

`ifdef MIPS150_FETCH_PERF_EN
        // Ten transfers interleaved with four stall cycles
        rst_n = 1'b0; step();
        rst_n = 1'b1;
        sample(); chk("perf_rst", fetch_count, 32'h0); advance();
        begin
            int base;
            int stalls;
            base   = xfers;
            stalls = 0;
            for (int k = 0; k < 60 && (xfers - base) < 10; k++) begin
                if ((xfers - base) >= 2 && stalls < 4 && (k % 2) == 0) begin
                    instr_ready = 1'b0;
                    stalls++;
                end else begin
                    instr_ready = 1'b1;
                end
                step();
            end
            instr_ready = 1'b0;
            sample();
            chk("perf_xfers", 32'(xfers - base), 32'd10);
            chk("perf_count", fetch_count, 32'd10);
            advance();
            instr_ready = 1'b1;
        end
`endif

        chkb("no_starvation", (max_starve <= 3), 1'b1);
        chkb("traffic_seen", (xfers > 100), 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips150_fetch.md
MIPS150_FETCH -- requirements
Module: mips150_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entry count; only 2 is supported.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port imem_req, output, 1, the instruction-memory read strobe.
REQ-006 SHALL have port imem_addr, output, 32, the byte address of the read, always word-aligned.
REQ-007 SHALL have port imem_rdata, input, 32, the read data, valid exactly one cycle after imem_req (synchronous BRAM).
REQ-008 SHALL have port redirect, input, 1, a one-cycle pulse requesting a PC change.
REQ-009 SHALL have port redirect_pc, input, 32, the target byte address, sampled when redirect=1.
REQ-010 SHALL have port instr, output, 32, the instruction word presented to the decoder.
REQ-011 SHALL have port instr_pc, output, 32, the byte address of instr.
REQ-012 SHALL have port instr_valid, output, 1, meaning instr/instr_pc are valid.
REQ-013 SHALL have port instr_ready, input, 1; a transfer occurs in each cycle with instr_valid & instr_ready.

Function
REQ-014 SHALL implement FSM states IDLE (no fetch) and RUN; IDLE->RUN on the first clock edge with rst_n=1; RUN has no exit except reset.
REQ-015 SHALL drive imem_req=0 in IDLE.
REQ-016 SHALL assert imem_req in RUN when (buffer occupancy + outstanding reads - pop) < 2, where pop = instr_valid & instr_ready.
REQ-017 SHALL drive imem_addr equal to the fetch PC and advance the PC by 4 on each issued read, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-018 SHALL write imem_rdata and its address into the buffer at the end of the cycle after the read, so instr_valid rises two cycles after the corresponding imem_req.
REQ-019 SHALL sustain one instruction per cycle while instr_ready=1.
REQ-020 SHALL hold instr and instr_pc stable while instr_valid=1 and instr_ready=0, and SHALL never drop or duplicate an instruction.
REQ-021 SHALL, in a redirect cycle, force imem_req=0, suppress the buffer write of the arriving response, flush the buffer at the clock edge, and load the PC with {redirect_pc[31:2],2'b00}.
REQ-022 SHALL complete a handshake occurring in the redirect cycle normally; only the remaining entries are flushed.
REQ-023 SHALL issue the read for the redirect target in the cycle after the redirect and present it on instr with instr_valid three cycles after the redirect.
REQ-024 SHALL ignore redirect while in IDLE or while rst_n=0.

Reset
REQ-025 SHALL, on a clock edge with rst_n=0 (including mid-operation), enter IDLE, set PC=RESET_PC, empty the buffer, clear outstanding reads, and drive imem_req=0, instr_valid=0, instr=0, instr_pc=0 in the following cycle.
REQ-026 SHALL discard any response to a read issued before reset.

Configuration
REQ-027 SHALL, with macro MIPS150_FETCH_PERF_EN defined, add output port fetch_count (32 bits, reset 0) that increments by 1 on every transfer and wraps at 2^32.
REQ-028 SHALL, without MIPS150_FETCH_PERF_EN, omit fetch_count and its logic entirely; all other behaviour is identical.

Structure
REQ-029 SHALL take the FSM state encodings, the default RESET_PC and the buffer depth from the shared package mips150_pkg.
REQ-030 SHALL implement the 2-entry instruction/PC buffer as sub-module mips150_fetch_buf, with push, pop, flush, full, and empty ports.

Verification
REQ-031 SHALL test reset release with instr_ready=1 and memory returning word=address: instr_valid first asserts 2 cycles after the first imem_req; instr_pc runs 0x0, 0x4, 0x8 at one per cycle.
REQ-032 SHALL test instr_ready=0 for 5 cycles mid-stream: imem_req drops once 2 instructions are held or in flight; after release the sequence continues with no gap, loss or repeat.
REQ-033 SHALL test redirect to 0x0000_0103 with a full buffer: the next imem_addr is 0x100, instr_valid is 0 for two cycles, and the next delivered instr_pc is 0x100.
REQ-034 SHALL test redirect to 0xFFFF_FFFC: delivered instr_pc sequence is 0xFFFF_FFFC, then 0x0000_0000.
REQ-035 SHALL test rst_n=0 for one cycle with a full buffer: in the next cycle instr_valid=0 and imem_req=0; fetch restarts at RESET_PC and no pre-reset data appears.
REQ-036 SHALL test, with MIPS150_FETCH_PERF_EN defined, 10 transfers interleaved with 4 stall cycles: fetch_count=10.
